gnr_node_lanes: RTL
===================

GNR_NODE_LANES -- requirements
Module: gnr_node_lanes

Interface
REQ-001 The block SHALL expose these parameters, one per line: name, default, meaning.
- LANES, 2, number of independent state lanes (1..32).
- DIV_W, 2, width of the update-divider configuration.
- STABLE_W, 8, width of the stability counter.

REQ-002 The block SHALL expose these ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state changes on its rising edge.
- rst, in, 1, synchronous active-high reset.
- reset_nos, in, 1, network re-initialise strobe.
- init_state, in, 1, value loaded into every lane on reset_nos.
- start, in, LANES, per-lane step request.
- in_a, in, LANES, first regulator input per lane.
- in_b, in, LANES, second regulator input per lane.
- mode, in, 2, update function select: 00 majority, 01 AND, 10 OR, 11 buffer.
- div_cfg, in, DIV_W, update period in accepted starts; 0 and 1 both mean every start.
- stable_thr, in, STABLE_W, stability threshold.
- s, out, LANES, registered lane states.
- upd, out, LANES, registered one-cycle pulse: lane updated this step.
- stable_cnt, out, STABLE_W, count of consecutive no-change steps.
- stable, out, 1, combinational: stable_cnt >= stable_thr.

Function
REQ-003 Priority SHALL be rst > reset_nos > start, evaluated each cycle.
REQ-004 Each lane i SHALL hold a phase counter ph[i] of DIV_W bits.
REQ-005 On reset_nos, the block SHALL load s[i] <= init_state and ph[i] <= 0 for all lanes, clear upd, and clear stable_cnt.
REQ-006 On start[i] with ph[i]==0, lane i SHALL update s[i] <= f(in_a[i], in_b[i], s[i]) and assert upd[i] on the next cycle.
REQ-007 On start[i] with ph[i]!=0, s[i] SHALL hold and upd[i] SHALL be 0.
REQ-008 After an accepted start, with D = max(div_cfg,1), ph[i] SHALL become 0 if ph[i] >= D-1, else ph[i]+1. A div_cfg reduced mid-run therefore wraps immediately.
REQ-009 With no start[i], ph[i], s[i] SHALL hold and upd[i] SHALL be 0.
REQ-010 The update function f SHALL be, with a=in_a, b=in_b:
- mode 00: (a&b) | (s&(a|b)).
- mode 01: a&b.
- mode 10: a|b.
- mode 11: a.
mode is sampled in the update cycle.
REQ-011 A step SHALL be any cycle in which at least one lane updates per REQ-006.
REQ-012 On a step, stable_cnt SHALL clear to 0 if any updating lane's new s differs from its old s. Otherwise it SHALL increment, saturating at 2^STABLE_W-1.
REQ-013 stable_cnt SHALL hold in non-step cycles.
REQ-014 Lane updates SHALL have 1-cycle latency: s and upd are visible the cycle after start.
REQ-015 Lanes SHALL be fully independent; simultaneous starts on several lanes all update in the same cycle.
REQ-016 stable_thr==0 SHALL make stable constantly 1.

Reset
REQ-017 On rst, the block SHALL clear s=0, upd=0, ph=0 and stable_cnt=0, regardless of reset_nos or start.
REQ-018 rst asserted mid-sequence SHALL discard pending phase state; the first start after rst updates immediately.
REQ-019 reset_nos SHALL NOT require rst, and SHALL override a coincident start.

Verification
REQ-020 rst; reset_nos with init_state=1; then in_a=1, in_b=0, mode=00, start[0] once -> s[0] stays 1, upd[0]=1 one cycle later, stable_cnt=1.
REQ-021 div_cfg=2, start[0] held high 4 cycles, in_a=in_b=1, init_state=0 -> s[0] rises after the 1st start; upd[0] pulses after starts 1 and 3 only.
REQ-022 div_cfg=3, lane at ph=2, div_cfg changed to 2, start -> ph wraps to 0; the next start updates.
REQ-023 mode sweep on one lane with (a,b,s) in all 8 combinations -> s matches the REQ-010 table for each mode.
REQ-024 LANES=4, stable_thr=3; three steps with no change -> stable=1 after the 3rd step; one toggling step -> stable_cnt=0, stable=0. STABLE_W=2 held steady -> saturates at 3.
REQ-025 reset_nos and start asserted in the same cycle -> s=init_state, upd=0. rst and reset_nos asserted together -> s=0.

Source files
------------

// File: rtl/gnr_node_lanes.sv
// Purpose : per-lane gene-regulatory node update with a clock-divided step and a network stability counter.
// Latency : 1 cycle from start[i] to the updated s[i] and the upd[i] pulse.
// Backpressure: none; every start is consumed in the cycle it is presented.
//
// Ports:
//   clk, rst            - single clock, synchronous active-high reset
//   reset_nos/init_state- network re-initialise strobe and the value loaded into every lane
//   start, in_a, in_b   - per-lane step request and the two regulator inputs
//   mode                - update function: 00 majority, 01 AND, 10 OR, 11 buffer
//   div_cfg             - update period in accepted starts (0 and 1 both mean every start)
//   stable_thr          - threshold for the stable flag
//   s, upd              - registered lane states and one-cycle "lane updated" pulses
//   stable_cnt, stable  - consecutive no-change step count and (stable_cnt >= stable_thr)
module gnr_node_lanes #(
    parameter int LANES    = 2,
    parameter int DIV_W    = 2,
    parameter int STABLE_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                reset_nos,
    input  logic                init_state,
    input  logic [LANES-1:0]    start,
    input  logic [LANES-1:0]    in_a,
    input  logic [LANES-1:0]    in_b,
    input  logic [1:0]          mode,
    input  logic [DIV_W-1:0]    div_cfg,
    input  logic [STABLE_W-1:0] stable_thr,
    output logic [LANES-1:0]    s,
    output logic [LANES-1:0]    upd,
    output logic [STABLE_W-1:0] stable_cnt,
    output logic                stable
);

    logic [LANES-1:0]            s_q, s_d;
    logic [LANES-1:0]            upd_q, upd_d;
    logic [LANES-1:0][DIV_W-1:0] ph_q, ph_d;
    logic [STABLE_W-1:0]         stable_cnt_q, stable_cnt_d;

    logic [LANES-1:0]            f_vec;   // candidate next state for every lane
    logic [LANES-1:0]            acc;     // lanes that update this cycle
    logic [DIV_W-1:0]            div_m1;  // last phase value before wrapping

    // The update function is bitwise, so it is evaluated for all lanes at once.
    always_comb begin
        f_vec = '0;
        case (mode)
            2'b00:   f_vec = (in_a & in_b) | (s_q & (in_a | in_b));
            2'b01:   f_vec = in_a & in_b;
            2'b10:   f_vec = in_a | in_b;
            default: f_vec = in_a;
        endcase
    end

    // div_cfg of 0 behaves like 1: the phase never leaves 0.
    assign div_m1 = (div_cfg == '0) ? '0 : div_cfg - 1'b1;

    always_comb begin
        s_d          = s_q;
        upd_d        = '0;
        ph_d         = ph_q;
        stable_cnt_d = stable_cnt_q;
        acc          = '0;

        for (int i = 0; i < LANES; i++) begin
            acc[i] = start[i] && (ph_q[i] == '0);
        end

        if (reset_nos) begin
            s_d          = {LANES{init_state}};
            ph_d         = '0;
            stable_cnt_d = '0;
        end else begin
            // Any start advances the phase; using >= makes a reduced div_cfg wrap at once.
            for (int i = 0; i < LANES; i++) begin
                if (start[i]) begin
                    ph_d[i] = (ph_q[i] >= div_m1) ? '0 : ph_q[i] + 1'b1;
                end
            end

            s_d   = (s_q & ~acc) | (f_vec & acc);
            upd_d = acc;

            if (|acc) begin
                if (|((f_vec ^ s_q) & acc)) begin
                    stable_cnt_d = '0;
                end else if (stable_cnt_q != {STABLE_W{1'b1}}) begin
                    stable_cnt_d = stable_cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q          <= '0;
            upd_q        <= '0;
            ph_q         <= '0;
            stable_cnt_q <= '0;
        end else begin
            s_q          <= s_d;
            upd_q        <= upd_d;
            ph_q         <= ph_d;
            stable_cnt_q <= stable_cnt_d;
        end
    end

    assign s          = s_q;
    assign upd        = upd_q;
    assign stable_cnt = stable_cnt_q;
    assign stable     = (stable_cnt_q >= stable_thr);

endmodule
